// File: rtl/amba_axi_pkg.sv
// Shared AXI4 request/response bundles used on every link of the interconnect.
// Request fields travel master-to-slave (mosi); response and ready fields travel back (miso).
package amba_axi_pkg;

   typedef struct packed {
      logic [3:0]  awid;
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
      logic [3:0]  arid;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        arvalid;
      logic        rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic        awready;
      logic        wready;
      logic [3:0]  bid;
      logic [1:0]  bresp;
      logic        bvalid;
      logic        arready;
      logic [3:0]  rid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
   } s_axi_miso_t;

endpackage

// File: rtl/axi_outstanding_limiter_pkg.sv
// Local types for the outstanding-transaction limiter: drain FSM states and
// the count-width helper shared by the top and the counter sub-module.
package axi_outstanding_limiter_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      QUIESCED = 2'd2
   } drain_state_e;

   function automatic int unsigned cnt_width(input int unsigned max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/axi_outstanding_limiter_if.sv
// One AXI4 link carried as request/response struct pair; master drives mosi,
// slave drives miso.
interface axi_outstanding_limiter_if;
   import amba_axi_pkg::*;

   s_axi_mosi_t mosi;
   s_axi_miso_t miso;

   modport master (output mosi, input  miso);
   modport slave  (input  mosi, output miso);

endinterface

// File: rtl/axi_txn_counter.sv
// Outstanding-transaction counter for one address channel: limit compare,
// valid-stability hold flag, saturating count and underflow pulse.
module axi_txn_counter
   import axi_outstanding_limiter_pkg::*;
#(
   parameter  int unsigned MAX = 8,
   localparam int unsigned W   = cnt_width(MAX)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         admit,      // new requests may start (FSM in RUN)
   input  logic         req_valid,  // upstream address valid
   input  logic         req_ready,  // downstream address ready
   input  logic         dec,        // completing response handshake
   output logic         allow,
   output logic         hold,
   output logic         inc,
   output logic         underflow,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] LIMIT = W'(MAX);

   logic [W-1:0] cnt_q;
   logic         hold_q;

   // Only registered terms feed allow, so ready never reaches valid combinationally.
   assign allow     = !rst && ((admit && (cnt_q < LIMIT)) || hold_q);
   assign inc       = req_valid && allow && req_ready;
   assign underflow = dec && (cnt_q == '0);
   assign hold      = hold_q;
   assign cnt       = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         hold_q <= 1'b0;
      end else begin
         if (inc) begin
            hold_q <= 1'b0;
         end else if (req_valid && allow) begin
            hold_q <= 1'b1;
         end

         case ({inc, dec && !underflow})
            2'b10:   cnt_q <= cnt_q + W'(1);
            2'b01:   cnt_q <= cnt_q - W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Caps outstanding AXI4 writes and reads by gating AW/AR, with a drain/quiesce
// handshake; W, B and R pass straight through.
module axi_outstanding_limiter
   import amba_axi_pkg::*;
   import axi_outstanding_limiter_pkg::*;
#(
   parameter int unsigned MAX_WR_OUT = 8,
   parameter int unsigned MAX_RD_OUT = 8
) (
   input  logic                                clk,
   input  logic                                arst,
   input  s_axi_mosi_t                         slave_mosi_i,
   output s_axi_miso_t                         slave_miso_o,
   output s_axi_mosi_t                         master_mosi_o,
   input  s_axi_miso_t                         master_miso_i,
   input  logic                                drain_req_i,
   output logic                                drain_ack_o,
   output logic [cnt_width(MAX_WR_OUT)-1:0]    wr_out_o,
   output logic [cnt_width(MAX_RD_OUT)-1:0]    rd_out_o,
   output logic                                err_o,
   input  logic                                err_clr_i
);

   drain_state_e state_q, state_d;

   logic aw_allow, aw_hold, aw_hs, wr_under;
   logic ar_allow, ar_hold, ar_hs, rd_under;
   logic b_hs, r_last_hs, admit, idle;
   logic err_q;

   assign admit     = (state_q == RUN);
   assign b_hs      = master_miso_i.bvalid && slave_mosi_i.bready;
   assign r_last_hs = master_miso_i.rvalid && slave_mosi_i.rready && master_miso_i.rlast;

   axi_txn_counter #(.MAX(MAX_WR_OUT)) u_wr_cnt (
      .clk       (clk),
      .rst       (arst),
      .admit     (admit),
      .req_valid (slave_mosi_i.awvalid),
      .req_ready (master_miso_i.awready),
      .dec       (b_hs),
      .allow     (aw_allow),
      .hold      (aw_hold),
      .inc       (aw_hs),
      .underflow (wr_under),
      .cnt       (wr_out_o)
   );

   axi_txn_counter #(.MAX(MAX_RD_OUT)) u_rd_cnt (
      .clk       (clk),
      .rst       (arst),
      .admit     (admit),
      .req_valid (slave_mosi_i.arvalid),
      .req_ready (master_miso_i.arready),
      .dec       (r_last_hs),
      .allow     (ar_allow),
      .hold      (ar_hold),
      .inc       (ar_hs),
      .underflow (rd_under),
      .cnt       (rd_out_o)
   );

   always_comb begin
      master_mosi_o         = slave_mosi_i;
      master_mosi_o.awvalid = slave_mosi_i.awvalid && aw_allow;
      master_mosi_o.arvalid = slave_mosi_i.arvalid && ar_allow;
      slave_miso_o          = master_miso_i;
      slave_miso_o.awready  = master_miso_i.awready && aw_allow;
      slave_miso_o.arready  = master_miso_i.arready && ar_allow;
   end

   // Quiesce only on a cycle with nothing outstanding, nothing held and no handshake.
   assign idle = (wr_out_o == '0) && (rd_out_o == '0) && !aw_hold && !ar_hold &&
                 !(aw_hs || ar_hs || b_hs || r_last_hs);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (drain_req_i) state_d = DRAIN;
         DRAIN:    if (!drain_req_i) state_d = RUN;
                   else if (idle)    state_d = QUIESCED;
         QUIESCED: if (!drain_req_i) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= RUN;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (wr_under || rd_under) begin
            err_q <= 1'b1;
         end else if (err_clr_i) begin
            err_q <= 1'b0;
         end
      end
   end

   assign drain_ack_o = (state_q == QUIESCED);
   assign err_o       = err_q;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Scenario bench for axi_outstanding_limiter (MAX_WR_OUT=2, MAX_RD_OUT=4); address
// handshakes are checked against a scoreboard of issued addresses.
module tb_axi_outstanding_limiter;
   import amba_axi_pkg::*;
   import axi_outstanding_limiter_pkg::*;

   localparam int unsigned MAX_WR = 2;
   localparam int unsigned MAX_RD = 4;

   logic clk = 1'b0;
   logic arst, drain_req, err_clr, drain_ack, err;
   logic [cnt_width(MAX_WR)-1:0] wr_out;
   logic [cnt_width(MAX_RD)-1:0] rd_out;

   axi_outstanding_limiter_if up_if ();
   axi_outstanding_limiter_if dn_if ();

   int total = 0;
   int bad   = 0;
   logic [31:0] aw_q[$];
   logic [31:0] ar_q[$];
   logic [31:0] aw_exp, ar_exp;

   always #5 clk = ~clk;

   axi_outstanding_limiter #(.MAX_WR_OUT(MAX_WR), .MAX_RD_OUT(MAX_RD)) dut (
      .clk           (clk),
      .arst          (arst),
      .slave_mosi_i  (up_if.mosi),
      .slave_miso_o  (up_if.miso),
      .master_mosi_o (dn_if.mosi),
      .master_miso_i (dn_if.miso),
      .drain_req_i   (drain_req),
      .drain_ack_o   (drain_ack),
      .wr_out_o      (wr_out),
      .rd_out_o      (rd_out),
      .err_o         (err),
      .err_clr_i     (err_clr)
   );

   // Downstream address handshakes must carry the addresses issued, in order.
   always @(negedge clk) begin
      if (arst === 1'b0 && dn_if.mosi.awvalid === 1'b1 && dn_if.miso.awready === 1'b1) begin
         total++;
         if (aw_q.size() == 0) begin
            bad++;
            $display("FAIL aw_scoreboard: unexpected awaddr=%0h, none pending", dn_if.mosi.awaddr);
         end else begin
            aw_exp = aw_q.pop_front();
            if (dn_if.mosi.awaddr !== aw_exp) begin
               bad++;
               $display("FAIL aw_scoreboard: got awaddr=%0h want %0h", dn_if.mosi.awaddr, aw_exp);
            end
         end
      end
      if (arst === 1'b0 && dn_if.mosi.arvalid === 1'b1 && dn_if.miso.arready === 1'b1) begin
         total++;
         if (ar_q.size() == 0) begin
            bad++;
            $display("FAIL ar_scoreboard: unexpected araddr=%0h, none pending", dn_if.mosi.araddr);
         end else begin
            ar_exp = ar_q.pop_front();
            if (dn_if.mosi.araddr !== ar_exp) begin
               bad++;
               $display("FAIL ar_scoreboard: got araddr=%0h want %0h", dn_if.mosi.araddr, ar_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      up_if.mosi        = '0;
      up_if.mosi.bready = 1'b1;
      up_if.mosi.rready = 1'b1;
      dn_if.miso         = '0;
      dn_if.miso.awready = 1'b1;
      dn_if.miso.wready  = 1'b1;
      dn_if.miso.arready = 1'b1;
      drain_req = 1'b0;
      err_clr   = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      set_idle();
      up_if.mosi.awvalid = 1'b1;
      up_if.mosi.arvalid = 1'b1;
      #1;
      total++; if (dn_if.mosi.awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid: got %b want 0", dn_if.mosi.awvalid); end
      total++; if (up_if.miso.awready !== 1'b0) begin bad++; $display("FAIL rst_awready: got %b want 0", up_if.miso.awready); end
      total++; if (dn_if.mosi.arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", dn_if.mosi.arvalid); end
      total++; if (wr_out !== 2'd0) begin bad++; $display("FAIL rst_wr_out: got %0d want 0", wr_out); end
      total++; if (rd_out !== 3'd0) begin bad++; $display("FAIL rst_rd_out: got %0d want 0", rd_out); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
      total++; if (drain_ack !== 1'b0) begin bad++; $display("FAIL rst_drain_ack: got %b want 0", drain_ack); end
      up_if.mosi.awvalid = 1'b0;
      up_if.mosi.arvalid = 1'b0;
      cyc();
      cyc();
      arst = 1'b0;
   endtask

   task automatic test_aw_limit();
      cyc();
      up_if.mosi.awaddr = 32'hA000_0000; up_if.mosi.awvalid = 1'b1; aw_q.push_back(32'hA000_0000);
      #3;
      total++; if (dn_if.mosi.awvalid !== 1'b1) begin bad++; $display("FAIL aw_open: got %b want 1", dn_if.mosi.awvalid); end
      cyc();
      up_if.mosi.awaddr = 32'hA000_0010; aw_q.push_back(32'hA000_0010);
      cyc();
      up_if.mosi.awaddr = 32'hA000_0020; aw_q.push_back(32'hA000_0020);
      #3;
      total++; if (dn_if.mosi.awvalid !== 1'b0) begin bad++; $display("FAIL aw_limit_valid: got %b want 0", dn_if.mosi.awvalid); end
      total++; if (up_if.miso.awready !== 1'b0) begin bad++; $display("FAIL aw_limit_ready: got %b want 0", up_if.miso.awready); end
      total++; if (wr_out !== 2'd2) begin bad++; $display("FAIL aw_limit_cnt: got %0d want 2", wr_out); end
      cyc();
      #3;
      total++; if (dn_if.mosi.awvalid !== 1'b0) begin bad++; $display("FAIL aw_limit_stay: got %b want 0", dn_if.mosi.awvalid); end
      cyc();
      dn_if.miso.bvalid = 1'b1; dn_if.miso.bid = 4'h5;
      #3;
      total++; if (up_if.miso.bvalid !== 1'b1 || up_if.miso.bid !== 4'h5) begin bad++; $display("FAIL b_pass: got bvalid=%b bid=%0h want 1/5", up_if.miso.bvalid, up_if.miso.bid); end
      total++; if (dn_if.mosi.awvalid !== 1'b0) begin bad++; $display("FAIL aw_boundary_block: got %b want 0", dn_if.mosi.awvalid); end
      cyc();
      dn_if.miso.bvalid = 1'b0;
      #3;
      total++; if (dn_if.mosi.awvalid !== 1'b1) begin bad++; $display("FAIL aw_reopen: got %b want 1", dn_if.mosi.awvalid); end
      total++; if (wr_out !== 2'd1) begin bad++; $display("FAIL aw_reopen_cnt: got %0d want 1", wr_out); end
      cyc();
      up_if.mosi.awvalid = 1'b0;
      total++; if (wr_out !== 2'd2) begin bad++; $display("FAIL aw_third_cnt: got %0d want 2", wr_out); end
      dn_if.miso.bvalid = 1'b1;
      cyc();
      cyc();
      dn_if.miso.bvalid = 1'b0;
      total++; if (wr_out !== 2'd0) begin bad++; $display("FAIL aw_retire_cnt: got %0d want 0", wr_out); end
   endtask

   task automatic test_simul_aw_b();
      up_if.mosi.awaddr = 32'hB000_0000; up_if.mosi.awvalid = 1'b1; aw_q.push_back(32'hB000_0000);
      cyc();
      up_if.mosi.awaddr = 32'hB000_0010; aw_q.push_back(32'hB000_0010);
      dn_if.miso.bvalid = 1'b1;
      cyc();
      up_if.mosi.awvalid = 1'b0;
      dn_if.miso.bvalid  = 1'b0;
      total++; if (wr_out !== 2'd1) begin bad++; $display("FAIL simul_cnt: got %0d want 1", wr_out); end
      dn_if.miso.bvalid = 1'b1;
      cyc();
      dn_if.miso.bvalid = 1'b0;
      total++; if (wr_out !== 2'd0) begin bad++; $display("FAIL simul_retire: got %0d want 0", wr_out); end
   endtask

   task automatic test_read_burst();
      logic [2:0]  exp_rd;
      logic [31:0] exp_data;
      up_if.mosi.araddr = 32'hC000_0000; up_if.mosi.arlen = 8'd3; up_if.mosi.arvalid = 1'b1;
      ar_q.push_back(32'hC000_0000);
      cyc();
      up_if.mosi.arvalid = 1'b0;
      total++; if (rd_out !== 3'd1) begin bad++; $display("FAIL rd_accept_cnt: got %0d want 1", rd_out); end
      for (int i = 0; i < 4; i++) begin
         exp_data = 32'hD0 + 32'(i);
         dn_if.miso.rvalid = 1'b1;
         dn_if.miso.rdata  = exp_data;
         dn_if.miso.rlast  = (i == 3);
         #3;
         total++; if (up_if.miso.rvalid !== 1'b1 || up_if.miso.rdata !== exp_data) begin bad++; $display("FAIL r_pass_%0d: got rdata=%0h want %0h", i, up_if.miso.rdata, exp_data); end
         cyc();
         exp_rd = (i == 3) ? 3'd0 : 3'd1;
         total++; if (rd_out !== exp_rd) begin bad++; $display("FAIL rd_beat_%0d_cnt: got %0d want %0d", i, rd_out, exp_rd); end
      end
      dn_if.miso.rvalid = 1'b0;
      dn_if.miso.rlast  = 1'b0;
   endtask

   task automatic test_drain();
      int n;
      dn_if.miso.awready = 1'b0;
      up_if.mosi.awaddr = 32'hE000_0000; up_if.mosi.awvalid = 1'b1; aw_q.push_back(32'hE000_0000);
      cyc();
      drain_req = 1'b1;
      #3;
      total++; if (dn_if.mosi.awvalid !== 1'b1) begin bad++; $display("FAIL drain_hold_valid: got %b want 1", dn_if.mosi.awvalid); end
      cyc();
      cyc();
      #3;
      total++; if (dn_if.mosi.awvalid !== 1'b1) begin bad++; $display("FAIL drain_hold_stay: got %b want 1", dn_if.mosi.awvalid); end
      total++; if (drain_ack !== 1'b0) begin bad++; $display("FAIL drain_ack_early: got %b want 0", drain_ack); end
      cyc();
      dn_if.miso.awready = 1'b1;
      cyc();
      up_if.mosi.awvalid = 1'b0;
      total++; if (wr_out !== 2'd1) begin bad++; $display("FAIL drain_hold_cnt: got %0d want 1", wr_out); end
      dn_if.miso.bvalid = 1'b1;
      cyc();
      dn_if.miso.bvalid = 1'b0;
      n = 0;
      while (drain_ack !== 1'b1 && n < 10) begin
         cyc();
         n++;
      end
      total++; if (drain_ack !== 1'b1) begin bad++; $display("FAIL drain_ack_timeout: got %b want 1", drain_ack); end
      total++; if (n !== 1) begin bad++; $display("FAIL drain_ack_latency: got %0d cycles want 1", n); end
      up_if.mosi.araddr = 32'hF000_0000; up_if.mosi.arlen = 8'd0; up_if.mosi.arvalid = 1'b1;
      ar_q.push_back(32'hF000_0000);
      #3;
      total++; if (dn_if.mosi.arvalid !== 1'b0 || up_if.miso.arready !== 1'b0) begin bad++; $display("FAIL quiesced_ar_block: got arvalid=%b arready=%b want 0/0", dn_if.mosi.arvalid, up_if.miso.arready); end
      cyc();
      cyc();
      drain_req = 1'b0;
      #3;
      total++; if (dn_if.mosi.arvalid !== 1'b0) begin bad++; $display("FAIL release_same_cycle: got %b want 0", dn_if.mosi.arvalid); end
      cyc();
      total++; if (drain_ack !== 1'b0) begin bad++; $display("FAIL drain_ack_drop: got %b want 0", drain_ack); end
      #3;
      total++; if (dn_if.mosi.arvalid !== 1'b1) begin bad++; $display("FAIL release_ar_open: got %b want 1", dn_if.mosi.arvalid); end
      cyc();
      up_if.mosi.arvalid = 1'b0;
      total++; if (rd_out !== 3'd1) begin bad++; $display("FAIL release_rd_cnt: got %0d want 1", rd_out); end
      dn_if.miso.rvalid = 1'b1; dn_if.miso.rlast = 1'b1;
      cyc();
      dn_if.miso.rvalid = 1'b0; dn_if.miso.rlast = 1'b0;
      total++; if (rd_out !== 3'd0) begin bad++; $display("FAIL release_rd_retire: got %0d want 0", rd_out); end
   endtask

   task automatic test_error();
      dn_if.miso.bvalid = 1'b1;
      cyc();
      dn_if.miso.bvalid = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_b_underflow: got %b want 1", err); end
      total++; if (wr_out !== 2'd0) begin bad++; $display("FAIL err_wr_sat: got %0d want 0", wr_out); end
      err_clr = 1'b1;
      dn_if.miso.rvalid = 1'b1; dn_if.miso.rlast = 1'b1;
      cyc();
      err_clr = 1'b0;
      dn_if.miso.rvalid = 1'b0; dn_if.miso.rlast = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set_wins: got %b want 1", err); end
      total++; if (rd_out !== 3'd0) begin bad++; $display("FAIL err_rd_sat: got %0d want 0", rd_out); end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
   endtask

   task automatic test_reset_mid();
      up_if.mosi.awaddr = 32'h1000_0000; up_if.mosi.awvalid = 1'b1; aw_q.push_back(32'h1000_0000);
      cyc();
      up_if.mosi.awaddr = 32'h1000_0010; aw_q.push_back(32'h1000_0010);
      cyc();
      up_if.mosi.awaddr = 32'h1000_0020; aw_q.push_back(32'h1000_0020);
      total++; if (wr_out !== 2'd2) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 2", wr_out); end
      #1;
      arst = 1'b1;
      #1;
      total++; if (wr_out !== 2'd0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", wr_out); end
      total++; if (dn_if.mosi.awvalid !== 1'b0 || up_if.miso.awready !== 1'b0) begin bad++; $display("FAIL mid_rst_gate: got awvalid=%b awready=%b want 0/0", dn_if.mosi.awvalid, up_if.miso.awready); end
      aw_q.delete();
      up_if.mosi.awvalid = 1'b0;
      cyc();
      arst = 1'b0;
      dn_if.miso.bvalid = 1'b1;
      cyc();
      dn_if.miso.bvalid = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL mid_inflight_err: got %b want 1", err); end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      up_if.mosi.awaddr = 32'h1000_0030; up_if.mosi.awvalid = 1'b1; aw_q.push_back(32'h1000_0030);
      cyc();
      up_if.mosi.awvalid = 1'b0;
      total++; if (wr_out !== 2'd1) begin bad++; $display("FAIL mid_resume_cnt: got %0d want 1", wr_out); end
      dn_if.miso.bvalid = 1'b1;
      cyc();
      dn_if.miso.bvalid = 1'b0;
      total++; if (wr_out !== 2'd0) begin bad++; $display("FAIL mid_resume_retire: got %0d want 0", wr_out); end
   endtask

   initial begin
      test_reset();
      test_aw_limit();
      test_simul_aw_b();
      test_read_burst();
      test_drain();
      test_error();
      test_reset_mid();
      cyc();
      total++; if (aw_q.size() != 0) begin bad++; $display("FAIL aw_leftover: got %0d pending want 0", aw_q.size()); end
      total++; if (ar_q.size() != 0) begin bad++; $display("FAIL ar_leftover: got %0d pending want 0", ar_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
